op_sel_stage: RTL and testbench

- Parametrised successor to the single-operand ALU source mux. Resolves both ALU operands (op1, op2) with EX/MEM forwarding and widened immediate modes, then registers them into the execute stage.
- Sits between register-file read and ALU.
- Valid/ready handshake with a 2-entry elastic buffer (output register + skid register), so upstream can stall without a combinational ready path.

---
 rtl/op_sel_stage_if.sv | 47 ++++
 rtl/op_sel_stage.sv | 140 ++++++++++++++
 tb/tb_op_sel_stage.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/op_sel_stage_if.sv
// op_sel_stage_if: request, forwarding and result bundle for op_sel_stage.
// master = upstream/ALU side, slave = the operand-select stage.
interface op_sel_stage_if #(
   parameter int XLEN  = 32,
   parameter int IMM_W = 16,
   parameter int SA_W  = 5,
   parameter int RN_W  = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       src_sel;
   logic [RN_W-1:0]  rs_num;
   logic [RN_W-1:0]  rt_num;
   logic [XLEN-1:0]  rs_val;
   logic [XLEN-1:0]  rt_val;
   logic [SA_W-1:0]  sa;
   logic [IMM_W-1:0] imm;
   logic             fwd_ex_valid;
   logic [RN_W-1:0]  fwd_ex_num;
   logic [XLEN-1:0]  fwd_ex_data;
   logic             fwd_mem_valid;
   logic [RN_W-1:0]  fwd_mem_num;
   logic [XLEN-1:0]  fwd_mem_data;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  op1;
   logic [XLEN-1:0]  op2;
   logic             out_illegal;

   modport master (
      output in_valid, src_sel, rs_num, rt_num,
      output rs_val, rt_val, sa, imm,
      output fwd_ex_valid, fwd_ex_num, fwd_ex_data,
      output fwd_mem_valid, fwd_mem_num, fwd_mem_data,
      output out_ready,
      input  in_ready, out_valid, op1, op2, out_illegal
   );

   modport slave (
      input  in_valid, src_sel, rs_num, rt_num,
      input  rs_val, rt_val, sa, imm,
      input  fwd_ex_valid, fwd_ex_num, fwd_ex_data,
      input  fwd_mem_valid, fwd_mem_num, fwd_mem_data,
      input  out_ready,
      output in_ready, out_valid, op1, op2, out_illegal
   );
endinterface

// File: rtl/op_sel_stage.sv
// op_sel_stage: resolves ALU op1/op2 and registers them via a 2-entry
// elastic buffer. Macro OP_SEL_FWD_EN enables EX/MEM forwarding.
module op_sel_stage #(
   parameter int XLEN  = 32,
   parameter int IMM_W = 16,
   parameter int SA_W  = 5,
   parameter int RN_W  = 5
) (
   input  logic clk,
   input  logic rstn,
   op_sel_stage_if.slave bus
);

   if (XLEN < 2*IMM_W) begin : g_chk_imm
      $error("op_sel_stage: XLEN must be >= 2*IMM_W");
   end
   if (SA_W >= XLEN) begin : g_chk_sa
      $error("op_sel_stage: SA_W must be < XLEN");
   end

   logic [XLEN-1:0] w_rs;
   logic [XLEN-1:0] w_rt;
   logic [XLEN-1:0] w_op2;
   logic [XLEN-1:0] w_imm_z;
   logic            w_ill;
   logic            w_acc;
   logic            w_free;

   logic            r_out_valid;
   logic [XLEN-1:0] r_op1;
   logic [XLEN-1:0] r_op2;
   logic            r_ill;
   logic            r_sk_full;
   logic [XLEN-1:0] r_sk_op1;
   logic [XLEN-1:0] r_sk_op2;
   logic            r_sk_ill;

`ifdef OP_SEL_FWD_EN
   logic w_rs_ex;
   logic w_rs_mem;
   logic w_rt_ex;
   logic w_rt_mem;

   // r0 is hardwired, so it never takes a forwarded value
   assign w_rs_ex  = (bus.rs_num != '0) &&
                     bus.fwd_ex_valid &&
                     (bus.fwd_ex_num == bus.rs_num);
   assign w_rs_mem = (bus.rs_num != '0) &&
                     bus.fwd_mem_valid &&
                     (bus.fwd_mem_num == bus.rs_num);
   assign w_rt_ex  = (bus.rt_num != '0) &&
                     bus.fwd_ex_valid &&
                     (bus.fwd_ex_num == bus.rt_num);
   assign w_rt_mem = (bus.rt_num != '0) &&
                     bus.fwd_mem_valid &&
                     (bus.fwd_mem_num == bus.rt_num);

   always_comb begin
      w_rs = bus.rs_val;
      w_rt = bus.rt_val;
      if (w_rs_ex)
         w_rs = bus.fwd_ex_data;
      else if (w_rs_mem)
         w_rs = bus.fwd_mem_data;
      if (w_rt_ex)
         w_rt = bus.fwd_ex_data;
      else if (w_rt_mem)
         w_rt = bus.fwd_mem_data;
   end
`else
   logic w_unused_fwd;

   assign w_rs = bus.rs_val;
   assign w_rt = bus.rt_val;
   assign w_unused_fwd = ^{bus.rs_num, bus.rt_num,
                           bus.fwd_ex_valid, bus.fwd_ex_num,
                           bus.fwd_ex_data, bus.fwd_mem_valid,
                           bus.fwd_mem_num, bus.fwd_mem_data};
`endif

   assign w_imm_z = {{(XLEN-IMM_W){1'b0}}, bus.imm};

   always_comb begin
      w_op2 = '0;
      w_ill = 1'b0;
      unique case (bus.src_sel)
         3'b000: w_op2 = w_rt;
         3'b001: w_op2 = {{(XLEN-SA_W){1'b0}}, bus.sa};
         3'b010: w_op2 = {{(XLEN-IMM_W){bus.imm[IMM_W-1]}},
                          bus.imm};
         3'b011: w_op2 = w_imm_z;
         3'b100: w_op2 = w_imm_z << IMM_W;
         default: w_ill = 1'b1;
      endcase
   end

   assign w_free = !r_out_valid || bus.out_ready;
   assign w_acc  = bus.in_valid && !r_sk_full;

   // skid only fills while the output is held, so order is preserved
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_out_valid <= 1'b0;
         r_op1       <= '0;
         r_op2       <= '0;
         r_ill       <= 1'b0;
         r_sk_full   <= 1'b0;
         r_sk_op1    <= '0;
         r_sk_op2    <= '0;
         r_sk_ill    <= 1'b0;
      end else if (w_free) begin
         if (r_sk_full) begin
            r_out_valid <= 1'b1;
            r_op1       <= r_sk_op1;
            r_op2       <= r_sk_op2;
            r_ill       <= r_sk_ill;
            r_sk_full   <= 1'b0;
         end else if (w_acc) begin
            r_out_valid <= 1'b1;
            r_op1       <= w_rs;
            r_op2       <= w_op2;
            r_ill       <= w_ill;
         end else begin
            r_out_valid <= 1'b0;
         end
      end else if (w_acc) begin
         r_sk_full <= 1'b1;
         r_sk_op1  <= w_rs;
         r_sk_op2  <= w_op2;
         r_sk_ill  <= w_ill;
      end
   end

   assign bus.in_ready    = !r_sk_full;
   assign bus.out_valid   = r_out_valid;
   assign bus.op1         = r_op1;
   assign bus.op2         = r_op2;
   assign bus.out_illegal = r_ill;

endmodule

// File: tb/tb_op_sel_stage.sv
// tb_op_sel_stage: vector table, handshake/reset sequences and a
// randomized run against a queue-based reference model.
module tb_op_sel_stage;
   localparam int XLEN  = 32;
   localparam int IMM_W = 16;
   localparam int SA_W  = 5;
   localparam int RN_W  = 5;
`ifdef OP_SEL_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   op_sel_stage_if #(.XLEN(XLEN), .IMM_W(IMM_W),
                     .SA_W(SA_W), .RN_W(RN_W)) bus ();

   op_sel_stage #(.XLEN(XLEN), .IMM_W(IMM_W),
                  .SA_W(SA_W), .RN_W(RN_W)) u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   typedef struct {
      logic [2:0]  sel;
      logic [4:0]  rsn;
      logic [31:0] rsv;
      logic [4:0]  rtn;
      logic [31:0] rtv;
      logic [4:0]  sa;
      logic [15:0] imm;
      logic        exv;
      logic [4:0]  exn;
      logic [31:0] exd;
      logic        mv;
      logic [4:0]  mn;
      logic [31:0] md;
   } req_t;

   typedef struct {
      logic [31:0] op1;
      logic [31:0] op2;
      logic        ill;
   } res_t;

   typedef struct {
      req_t r;
      res_t e;
   } vec_t;

   int   n_chk  = 0;
   int   n_fail = 0;
   res_t q[$];
   vec_t tbl[11];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic [2:0] sel, input logic [4:0] rsn,
      input logic [31:0] rsv, input logic [4:0] rtn,
      input logic [31:0] rtv, input logic [4:0] sa,
      input logic [15:0] imm, input logic exv,
      input logic [4:0] exn, input logic [31:0] exd,
      input logic mv, input logic [4:0] mn, input logic [31:0] md,
      input logic [31:0] e1, input logic [31:0] e2, input logic ei);
      vec_t v;
      v.r.sel = sel; v.r.rsn = rsn; v.r.rsv = rsv;
      v.r.rtn = rtn; v.r.rtv = rtv; v.r.sa = sa;
      v.r.imm = imm; v.r.exv = exv; v.r.exn = exn;
      v.r.exd = exd; v.r.mv = mv; v.r.mn = mn; v.r.md = md;
      v.e.op1 = e1; v.e.op2 = e2; v.e.ill = ei;
      return v;
   endfunction

   // reference: register value after the forwarding rules
   function automatic logic [31:0] resolve(input logic [4:0] n,
                                           input logic [31:0] v,
                                           input req_t r);
      if (FWD && n != 0 && r.exv && r.exn == n) return r.exd;
      if (FWD && n != 0 && r.mv && r.mn == n) return r.md;
      return v;
   endfunction

   function automatic res_t model(input req_t r);
      res_t o;
      o.op1 = resolve(r.rsn, r.rsv, r);
      o.ill = 1'b0;
      case (r.sel)
         3'd0: o.op2 = resolve(r.rtn, r.rtv, r);
         3'd1: o.op2 = 32'(r.sa);
         3'd2: o.op2 = r.imm[15] ? 32'(r.imm) - 32'h10000
                                 : 32'(r.imm);
         3'd3: o.op2 = 32'(r.imm);
         3'd4: o.op2 = 32'(r.imm) * 32'h10000;
         default: begin
            o.op2 = 32'h0;
            o.ill = 1'b1;
         end
      endcase
      return o;
   endfunction

   task automatic apply(input req_t r);
      bus.src_sel       = r.sel;
      bus.rs_num        = r.rsn;
      bus.rs_val        = r.rsv;
      bus.rt_num        = r.rtn;
      bus.rt_val        = r.rtv;
      bus.sa            = r.sa;
      bus.imm           = r.imm;
      bus.fwd_ex_valid  = r.exv;
      bus.fwd_ex_num    = r.exn;
      bus.fwd_ex_data   = r.exd;
      bus.fwd_mem_valid = r.mv;
      bus.fwd_mem_num   = r.mn;
      bus.fwd_mem_data  = r.md;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input res_t e);
      chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, " op1"}, bus.op1, e.op1);
      chk({tag, " op2"}, bus.op2, e.op2);
      chk({tag, " out_illegal"}, 32'(bus.out_illegal), 32'(e.ill));
   endtask

   initial begin
      vec_t va;
      vec_t vb;
      vec_t vc;
      req_t rr;
      res_t ef;
      bit   acc;
      bit   drn;

      tbl[0]  = mk(3'b010, 5'd1, 32'h11111111, 5'd2, 32'h0, 5'd0,
                   16'h8001, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                   32'h11111111, 32'hFFFF8001, 0);
      tbl[1]  = mk(3'b100, 5'd1, 32'h1, 5'd2, 32'h2, 5'd0,
                   16'h1234, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                   32'h1, 32'h12340000, 0);
      tbl[2]  = mk(3'b001, 5'd6, 32'h66, 5'd2, 32'h2, 5'd31,
                   16'hFFFF, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                   32'h66, 32'h0000001F, 0);
      tbl[3]  = mk(3'b011, 5'd6, 32'h66, 5'd2, 32'h2, 5'd3,
                   16'h8001, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                   32'h66, 32'h00008001, 0);
      tbl[4]  = mk(3'b000, 5'd3, 32'h33, 5'd4, 32'h44, 5'd0,
                   16'h0, 1, 5'd3, 32'hAAAA0000, 1, 5'd3, 32'h5555,
                   FWD ? 32'hAAAA0000 : 32'h33, 32'h44, 0);
      tbl[5]  = mk(3'b000, 5'd3, 32'h33, 5'd3, 32'h44, 5'd0,
                   16'h0, 1, 5'd7, 32'hAAAA0000, 1, 5'd3, 32'h5555,
                   FWD ? 32'h5555 : 32'h33,
                   FWD ? 32'h5555 : 32'h44, 0);
      tbl[6]  = mk(3'b000, 5'd0, 32'h77, 5'd0, 32'h88, 5'd0,
                   16'h0, 1, 5'd0, 32'hDEAD0000, 1, 5'd0, 32'hDEAD,
                   32'h77, 32'h88, 0);
      tbl[7]  = mk(3'b110, 5'd5, 32'h55, 5'd2, 32'h22, 5'd9,
                   16'h1234, 1, 5'd5, 32'hBEEF, 0, 5'd0, 32'h0,
                   FWD ? 32'hBEEF : 32'h55, 32'h0, 1);
      tbl[8]  = mk(3'b000, 5'd5, 32'h55, 5'd2, 32'h22, 5'd9,
                   16'h1234, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                   32'h55, 32'h22, 0);
      tbl[9]  = mk(3'b111, 5'd8, 32'h8, 5'd2, 32'h22, 5'd9,
                   16'h1234, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                   32'h8, 32'h0, 1);
      tbl[10] = mk(3'b000, 5'd9, 32'h9, 5'd10, 32'hA, 5'd0,
                   16'h0, 0, 5'd9, 32'h1111, 1, 5'd9, 32'h2222,
                   FWD ? 32'h2222 : 32'h9, 32'hA, 0);

      apply(tbl[8].r);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset op1", bus.op1, 32'h0);
      chk("reset op2", bus.op2, 32'h0);
      chk("reset out_illegal", 32'(bus.out_illegal), 32'd0);
      #2 rstn = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) begin
         apply(tbl[i].r);
         bus.in_valid  = 1'b1;
         bus.out_ready = 1'b1;
         tick();
         bus.in_valid = 1'b0;
         chk_out($sformatf("vec%0d", i), tbl[i].e);
         tick();
      end
      chk("drained out_valid", 32'(bus.out_valid), 32'd0);

      va = mk(3'b011, 5'd1, 32'hA1, 5'd2, 32'h0, 5'd0, 16'h00AA,
              0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 32'hA1, 32'hAA, 0);
      vb = mk(3'b011, 5'd1, 32'hB1, 5'd2, 32'h0, 5'd0, 16'h00BB,
              0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 32'hB1, 32'hBB, 0);
      vc = mk(3'b011, 5'd1, 32'hC1, 5'd2, 32'h0, 5'd0, 16'h00CC,
              0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 32'hC1, 32'hCC, 0);

      bus.out_ready = 1'b0;
      apply(va.r);
      bus.in_valid = 1'b1;
      tick();
      chk_out("bp A", va.e);
      chk("bp in_ready after A", 32'(bus.in_ready), 32'd1);
      apply(vb.r);
      tick();
      chk("bp in_ready after B", 32'(bus.in_ready), 32'd0);
      chk_out("bp hold A", va.e);
      apply(vc.r);
      tick();
      tick();
      chk_out("bp ignore C", va.e);
      chk("bp in_ready held", 32'(bus.in_ready), 32'd0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk_out("bp B", vb.e);
      chk("bp in_ready back", 32'(bus.in_ready), 32'd1);
      tick();
      chk("bp empty", 32'(bus.out_valid), 32'd0);

      bus.out_ready = 1'b0;
      apply(va.r);
      bus.in_valid = 1'b1;
      tick();
      apply(vb.r);
      tick();
      bus.in_valid = 1'b0;
      chk("ar skid full", 32'(bus.in_ready), 32'd0);
      #2 rstn = 1'b0;
      #1;
      chk("ar out_valid", 32'(bus.out_valid), 32'd0);
      chk("ar in_ready", 32'(bus.in_ready), 32'd1);
      chk("ar op1", bus.op1, 32'h0);
      chk("ar op2", bus.op2, 32'h0);
      #1 rstn = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      chk("ar no stale", 32'(bus.out_valid), 32'd0);
      tick();
      chk("ar no stale 2", 32'(bus.out_valid), 32'd0);
      apply(vc.r);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk_out("ar fresh C", vc.e);
      tick();

      q.delete();
      for (int c = 0; c < 600; c++) begin
         chk("rnd out_valid", 32'(bus.out_valid),
             32'(q.size() > 0));
         chk("rnd in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
         if (q.size() > 0) begin
            ef = q[0];
            chk("rnd op1", bus.op1, ef.op1);
            chk("rnd op2", bus.op2, ef.op2);
            chk("rnd out_illegal", 32'(bus.out_illegal),
                32'(ef.ill));
         end
         rr.sel = 3'($urandom_range(0, 7));
         rr.rsn = 5'($urandom_range(0, 3));
         rr.rsv = $urandom;
         rr.rtn = 5'($urandom_range(0, 3));
         rr.rtv = $urandom;
         rr.sa  = 5'($urandom);
         rr.imm = 16'($urandom);
         rr.exv = 1'($urandom);
         rr.exn = 5'($urandom_range(0, 3));
         rr.exd = $urandom;
         rr.mv  = 1'($urandom);
         rr.mn  = 5'($urandom_range(0, 3));
         rr.md  = $urandom;
         apply(rr);
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         acc = bus.in_valid && (q.size() < 2);
         drn = bus.out_ready && (q.size() > 0);
         if (drn) void'(q.pop_front());
         if (acc) q.push_back(model(rr));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
